// File: rtl/dda_run_ctrl.sv
// Run sequencer for the posit spring-mass DDA: init, settle, step, and a decimated
// (v1, v2) sample stream with valid/ready backpressure that stalls integration.
module dda_run_ctrl #(
    parameter int N          = 16,
    parameter int SETTLE_CYC = 4,
    parameter int STEPW      = 16,
    parameter int DECW       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [STEPW-1:0] num_steps,
    input  logic [DECW-1:0]  decim,
    input  logic [N-1:0]     dda_v1,
    input  logic [N-1:0]     dda_v2,
    output logic             dda_en,
    output logic             dda_init_n,
    output logic [N-1:0]     sample_v1,
    output logic [N-1:0]     sample_v2,
    output logic [STEPW-1:0] sample_idx,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             busy,
    output logic             done
);

    localparam int WAITW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [WAITW-1:0] WAIT_INIT = WAITW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT,
        S_OUT,
        S_STEP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [STEPW-1:0] num_steps_l_q, num_steps_l_d;
    logic [DECW-1:0]  decim_l_q, decim_l_d;
    logic [STEPW-1:0] step_cnt_q, step_cnt_d;
    logic [DECW-1:0]  dec_cnt_q, dec_cnt_d;
    logic [WAITW-1:0] wait_cnt_q, wait_cnt_d;
    logic [N-1:0]     sample_v1_q, sample_v1_d;
    logic [N-1:0]     sample_v2_q, sample_v2_d;
    logic [STEPW-1:0] sample_idx_q, sample_idx_d;
    logic             last_step;

    assign last_step = (step_cnt_q == num_steps_l_q);

    always_comb begin
        state_d       = state_q;
        num_steps_l_d = num_steps_l_q;
        decim_l_d     = decim_l_q;
        step_cnt_d    = step_cnt_q;
        dec_cnt_d     = dec_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        sample_v1_d   = sample_v1_q;
        sample_v2_d   = sample_v2_q;
        sample_idx_d  = sample_idx_q;

        // abort outranks every transition, including a same-cycle transfer
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_steps_l_d = num_steps;
                        decim_l_d     = (decim == '0) ? DECW'(1) : decim;
                        step_cnt_d    = '0;
                        dec_cnt_d     = '0;
                        state_d       = S_INIT;
                    end
                end
                S_INIT: begin
                    wait_cnt_d = WAIT_INIT;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_q != '0) begin
                        wait_cnt_d = wait_cnt_q - WAITW'(1);
                    end else if ((dec_cnt_q == '0) || last_step) begin
                        sample_v1_d  = dda_v1;
                        sample_v2_d  = dda_v2;
                        sample_idx_d = step_cnt_q;
                        state_d      = S_OUT;
                    end else begin
                        state_d = S_STEP;
                    end
                end
                S_OUT: begin
                    if (sample_ready) begin
                        state_d = last_step ? S_DONE : S_STEP;
                    end
                end
                S_STEP: begin
                    step_cnt_d = step_cnt_q + STEPW'(1);
                    dec_cnt_d  = (dec_cnt_q == decim_l_q - DECW'(1)) ? '0 : dec_cnt_q + DECW'(1);
                    wait_cnt_d = WAIT_INIT;
                    state_d    = S_WAIT;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            num_steps_l_q <= '0;
            decim_l_q     <= '0;
            step_cnt_q    <= '0;
            dec_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            sample_v1_q   <= '0;
            sample_v2_q   <= '0;
            sample_idx_q  <= '0;
        end else begin
            state_q       <= state_d;
            num_steps_l_q <= num_steps_l_d;
            decim_l_q     <= decim_l_d;
            step_cnt_q    <= step_cnt_d;
            dec_cnt_q     <= dec_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            sample_v1_q   <= sample_v1_d;
            sample_v2_q   <= sample_v2_d;
            sample_idx_q  <= sample_idx_d;
        end
    end

    // every control output is a pure decode of the state register
    assign dda_en       = (state_q == S_INIT) || (state_q == S_STEP);
    assign dda_init_n   = (state_q != S_INIT);
    assign sample_valid = (state_q == S_OUT);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign sample_v1    = sample_v1_q;
    assign sample_v2    = sample_v2_q;
    assign sample_idx   = sample_idx_q;

endmodule

// File: tb/tb_dda_run_ctrl.sv
// Bench for dda_run_ctrl: a toy DDA stand-in plus an arithmetic reference for
// which step indices are sampled and what v1/v2 hold at each step.
module tb_dda_run_ctrl;

    localparam int N     = 16;
    localparam int S     = 4;
    localparam int STEPW = 16;
    localparam int DECW  = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             sample_ready = 1'b0;
    logic [STEPW-1:0] num_steps = '0;
    logic [DECW-1:0]  decim = '0;
    logic [N-1:0]     dda_v1 = 16'hdead;
    logic [N-1:0]     dda_v2 = 16'hbeef;
    logic [N-1:0]     sample_v1, sample_v2;
    logic [STEPW-1:0] sample_idx;
    logic             dda_en, dda_init_n, sample_valid, busy, done;
    logic [N-1:0]     ic1 = 16'h4000;
    logic [N-1:0]     ic2 = 16'h0000;

    int compared = 0;
    int mismatched = 0;

    int n_init, n_step, n_done, first_rise, second_rise, stall_bad, stall_en, stall_rem;
    logic [15:0] q_idx[$];
    logic [15:0] q_v1[$];
    logic [15:0] q_v2[$];

    always #5 clk = ~clk;

    dda_run_ctrl #(.N(N), .SETTLE_CYC(S), .STEPW(STEPW), .DECW(DECW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_steps(num_steps), .decim(decim),
        .dda_v1(dda_v1), .dda_v2(dda_v2),
        .dda_en(dda_en), .dda_init_n(dda_init_n),
        .sample_v1(sample_v1), .sample_v2(sample_v2), .sample_idx(sample_idx),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .busy(busy), .done(done)
    );

    // Toy DDA: loads ic when init, otherwise one arbitrary "Euler" update per enable.
    always @(posedge clk) begin
        if (dda_en) begin
            if (!dda_init_n) begin
                dda_v1 <= ic1;
                dda_v2 <= ic2;
            end else begin
                dda_v1 <= dda_v1 + dda_v2 + 16'h0123;
                dda_v2 <= dda_v2 - (dda_v1 >> 2) + 16'h0011;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_at(input int k, output logic [15:0] v1, output logic [15:0] v2);
        logic [15:0] nv1, nv2;
        v1 = ic1;
        v2 = ic2;
        for (int i = 0; i < k; i++) begin
            nv1 = v1 + v2 + 16'h0123;
            nv2 = v2 - (v1 >> 2) + 16'h0011;
            v1 = nv1;
            v2 = nv2;
        end
    endfunction

    task automatic run_collect(input int n, input int d, input int rdy_pct,
                               input int stall_idx, input int stall_len, input bit restart);
        int edges;
        bit finished, prev_v;
        logic [15:0] hv1, hv2, hidx;
        q_idx.delete(); q_v1.delete(); q_v2.delete();
        n_init = 0; n_step = 0; n_done = 0; first_rise = -1; second_rise = -1;
        stall_bad = 0; stall_en = 0; stall_rem = stall_len;
        hv1 = '0; hv2 = '0; hidx = '0;
        num_steps = n[STEPW-1:0];
        decim = d[DECW-1:0];
        sample_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        num_steps = STEPW'(n + 7);
        decim = DECW'(d + 1);
        edges = 1; finished = 1'b0; prev_v = 1'b0;
        while (!finished && edges < 4000) begin
            start = restart && (edges == 3);
            if (dda_en) begin
                if (!dda_init_n) n_init++;
                else n_step++;
            end
            if (done) begin
                n_done++;
                finished = 1'b1;
            end
            if (sample_valid && !prev_v) begin
                if (first_rise < 0) first_rise = edges;
                else if (second_rise < 0) second_rise = edges;
            end
            prev_v = sample_valid;
            if (sample_valid && (int'(sample_idx) == stall_idx) && stall_rem > 0) begin
                if (stall_rem == stall_len) {hv1, hv2, hidx} = {sample_v1, sample_v2, sample_idx};
                else if ({sample_v1, sample_v2, sample_idx} !== {hv1, hv2, hidx}) stall_bad++;
                if (dda_en) stall_en++;
                stall_rem--;
                sample_ready = 1'b0;
            end else begin
                sample_ready = ($urandom_range(99) < rdy_pct);
            end
            if (sample_valid && sample_ready) begin
                q_idx.push_back(sample_idx);
                q_v1.push_back(sample_v1);
                q_v2.push_back(sample_v2);
            end
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        sample_ready = 1'b0;
        chk("run_finished", finished, 1);
        chk("busy_after_done", busy, 0);
        chk("done_single_cycle", done, 0);
    endtask

    task automatic check_samples(input int n, input int d);
        int dd;
        int exp_idx[$];
        logic [15:0] ev1, ev2;
        dd = (d == 0) ? 1 : d;
        for (int k = 0; k <= n; k++)
            if ((k % dd) == 0 || k == n) exp_idx.push_back(k);
        chk("sample_count", q_idx.size(), exp_idx.size());
        for (int i = 0; i < exp_idx.size() && i < q_idx.size(); i++) begin
            model_at(exp_idx[i], ev1, ev2);
            chk("sample_idx", q_idx[i], exp_idx[i]);
            chk("sample_v1", q_v1[i], ev1);
            chk("sample_v2", q_v2[i], ev2);
        end
        chk("step_pulses", n_step, n);
        chk("init_pulses", n_init, 1);
        chk("done_pulses", n_done, 1);
    endtask

    initial begin
        int st, k, done_seen, n, d;

        #12;
        chk("rst_dda_en", dda_en, 0);
        chk("rst_init_n", dda_init_n, 1);
        chk("rst_valid", sample_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_v1", sample_v1, 0);
        chk("rst_v2", sample_v2, 0);
        chk("rst_idx", sample_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // num_steps=0: one sample of the initial conditions
        run_collect(0, 1, 100, -1, 0, 1'b0);
        check_samples(0, 1);
        chk("first_valid_latency", first_rise, S + 2);

        // decimation by 2 over 5 steps: idx 0, 2, 4, 5
        run_collect(5, 2, 100, -1, 0, 1'b0);
        check_samples(5, 2);

        // per-step cost with ready high and no decimation
        run_collect(4, 1, 100, -1, 0, 1'b0);
        check_samples(4, 1);
        chk("step_period", second_rise - first_rise, S + 2);

        // backpressure: hold ready low 10 cycles while idx 1 is offered
        run_collect(3, 1, 100, 1, 10, 1'b0);
        check_samples(3, 1);
        chk("stall_len_held", stall_rem, 0);
        chk("stall_data_stable", stall_bad, 0);
        chk("stall_no_dda_en", stall_en, 0);

        // abort in the WAIT following step 2 of 8
        num_steps = 16'd8;
        decim = 8'd1;
        sample_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        st = 0; k = 0;
        while (st < 2 && k < 200) begin
            if (dda_en && dda_init_n) st++;
            @(posedge clk); #1;
            k++;
        end
        chk("abort_reached_step2", st, 2);
        chk("abort_pre_busy", busy, 1);
        chk("abort_pre_valid", sample_valid, 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        sample_ready = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", sample_valid, 0);
        done_seen = done;
        repeat (3) begin
            @(posedge clk); #1;
            done_seen |= done;
        end
        chk("abort_no_done", done_seen, 0);
        run_collect(8, 1, 100, -1, 0, 1'b0);
        check_samples(8, 1);

        // start re-pulsed mid-run is ignored; decim=0 samples every step
        run_collect(4, 0, 100, -1, 0, 1'b1);
        check_samples(4, 0);

        // randomized runs with random backpressure
        for (int r = 0; r < 8; r++) begin
            ic1 = 16'($urandom);
            ic2 = 16'($urandom);
            n = int'($urandom_range(12));
            d = int'($urandom_range(4));
            run_collect(n, d, 65, -1, 0, 1'b0);
            check_samples(n, d);
        end

        // asynchronous reset while a sample is being offered
        ic1 = 16'h4000;
        ic2 = 16'h0000;
        num_steps = 16'd3;
        decim = 8'd1;
        sample_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!sample_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("arst_reached_out", sample_valid, 1);
        chk("arst_pre_v1", sample_v1, 16'h4000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", sample_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_dda_en", dda_en, 0);
        chk("arst_init_n", dda_init_n, 1);
        chk("arst_v1", sample_v1, 0);
        chk("arst_idx", sample_idx, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_idle_busy", busy, 0);
        chk("arst_idle_valid", sample_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
